// File: rtl/sme_host_tx.sv
// Host-side transmitter for the SME character-stream protocol: buffers a string and a pattern,
// serializes them to the SME, and returns its verdict. Define SME_TX_STAT_EN to build job/hit counters.
module sme_host_tx #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [7:0]  wr_data,
    input  logic        clr,
    input  logic        start,
    input  logic        send_str,
    output logic        busy,
    output logic        err,
    output logic [7:0]  sme_chardata,
    output logic        sme_isstring,
    output logic        sme_ispattern,
    input  logic        sme_valid,
    input  logic        sme_match,
    input  logic [4:0]  sme_match_index,
    output logic        res_valid,
    output logic        res_match,
    output logic [4:0]  res_index,
    output logic        res_timeout,
    output logic [15:0] stat_jobs,
    output logic [15:0] stat_hits
);
    localparam int SCW = $clog2(STR_MAX + 1);
    localparam int PCW = $clog2(PAT_MAX + 1);
    localparam int CW  = (SCW > PCW) ? SCW : PCW;
    localparam int SAW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int PAW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND_STR, S_SEND_PAT, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   str_cnt_q, str_cnt_d, pat_cnt_q, pat_cnt_d, rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            str_loaded_q, str_loaded_d;
    logic [7:0]      chardata_q, chardata_d;
    logic            isstring_q, isstring_d, ispattern_q, ispattern_d;
    logic            err_q, err_d;
    logic            res_match_q, res_match_d, res_timeout_q, res_timeout_d;
    logic [4:0]      res_index_q, res_index_d;
    logic            str_we, pat_we, start_bad;
    logic [7:0]      str_mem_q [STR_MAX];
    logic [7:0]      pat_mem_q [PAT_MAX];

    always_ff @(posedge clk) begin
        if (str_we) str_mem_q[str_cnt_q[SAW-1:0]] <= wr_data;
        if (pat_we) pat_mem_q[pat_cnt_q[PAW-1:0]] <= wr_data;
    end

    assign start_bad = (pat_cnt_q == '0) || (send_str && str_cnt_q == '0) ||
                       (!send_str && !str_loaded_q);

    always_comb begin
        state_d       = state_q;
        str_cnt_d     = str_cnt_q;
        pat_cnt_d     = pat_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        tmo_cnt_d     = tmo_cnt_q;
        str_loaded_d  = str_loaded_q;
        chardata_d    = chardata_q;
        isstring_d    = 1'b0;
        ispattern_d   = 1'b0;
        err_d         = 1'b0;
        res_match_d   = res_match_q;
        res_index_d   = res_index_q;
        res_timeout_d = res_timeout_q;
        str_we        = 1'b0;
        pat_we        = 1'b0;

        if (state_q != S_IDLE && wr_en && !clr) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    if (wr_sel) pat_cnt_d = '0;
                    else        str_cnt_d = '0;
                end else if (wr_en) begin
                    if (wr_sel) begin
                        if (pat_cnt_q == CW'(PAT_MAX)) err_d = 1'b1;
                        else begin
                            pat_we    = 1'b1;
                            pat_cnt_d = pat_cnt_q + CW'(1);
                        end
                    end else begin
                        if (str_cnt_q == CW'(STR_MAX)) err_d = 1'b1;
                        else begin
                            str_we    = 1'b1;
                            str_cnt_d = str_cnt_q + CW'(1);
                        end
                    end
                end
                // The first character is registered on the accepting edge, so it is on the bus next cycle.
                if (start) begin
                    if (start_bad) err_d = 1'b1;
                    else if (send_str) begin
                        state_d      = S_SEND_STR;
                        chardata_d   = str_mem_q[0];
                        isstring_d   = 1'b1;
                        rd_ptr_d     = CW'(1);
                        str_loaded_d = 1'b1;
                    end else begin
                        state_d     = S_SEND_PAT;
                        chardata_d  = pat_mem_q[0];
                        ispattern_d = 1'b1;
                        rd_ptr_d    = CW'(1);
                    end
                end
            end
            S_SEND_STR: begin
                if (rd_ptr_q < str_cnt_q) begin
                    chardata_d = str_mem_q[rd_ptr_q[SAW-1:0]];
                    isstring_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + CW'(1);
                end else begin
                    state_d     = S_SEND_PAT;
                    chardata_d  = pat_mem_q[0];
                    ispattern_d = 1'b1;
                    rd_ptr_d    = CW'(1);
                end
            end
            S_SEND_PAT: begin
                if (rd_ptr_q < pat_cnt_q) begin
                    chardata_d  = pat_mem_q[rd_ptr_q[PAW-1:0]];
                    ispattern_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + CW'(1);
                end else begin
                    state_d   = S_WAIT;
                    tmo_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // A verdict arriving on the final timeout cycle still counts as a real answer.
                if (sme_valid) begin
                    res_match_d   = sme_match;
                    res_index_d   = sme_match ? sme_match_index : 5'd0;
                    res_timeout_d = 1'b0;
                    state_d       = S_DONE;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    res_match_d   = 1'b0;
                    res_index_d   = 5'd0;
                    res_timeout_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            str_cnt_q     <= '0;
            pat_cnt_q     <= '0;
            rd_ptr_q      <= '0;
            tmo_cnt_q     <= '0;
            str_loaded_q  <= 1'b0;
            chardata_q    <= 8'd0;
            isstring_q    <= 1'b0;
            ispattern_q   <= 1'b0;
            err_q         <= 1'b0;
            res_match_q   <= 1'b0;
            res_index_q   <= 5'd0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            str_cnt_q     <= str_cnt_d;
            pat_cnt_q     <= pat_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            str_loaded_q  <= str_loaded_d;
            chardata_q    <= chardata_d;
            isstring_q    <= isstring_d;
            ispattern_q   <= ispattern_d;
            err_q         <= err_d;
            res_match_q   <= res_match_d;
            res_index_q   <= res_index_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign res_valid     = (state_q == S_DONE);
    assign err           = err_q;
    assign sme_chardata  = chardata_q;
    assign sme_isstring  = isstring_q;
    assign sme_ispattern = ispattern_q;
    assign res_match     = res_match_q;
    assign res_index     = res_index_q;
    assign res_timeout   = res_timeout_q;

`ifdef SME_TX_STAT_EN
    logic [15:0] stat_jobs_q, stat_jobs_d, stat_hits_q, stat_hits_d;

    always_comb begin
        stat_jobs_d = stat_jobs_q;
        stat_hits_d = stat_hits_q;
        if (state_q == S_DONE) begin
            stat_jobs_d = stat_jobs_q + 16'd1;
            if (res_match_q) stat_hits_d = stat_hits_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_jobs_q <= 16'd0;
            stat_hits_q <= 16'd0;
        end else begin
            stat_jobs_q <= stat_jobs_d;
            stat_hits_q <= stat_hits_d;
        end
    end

    assign stat_jobs = stat_jobs_q;
    assign stat_hits = stat_hits_q;
`else
    assign stat_jobs = 16'd0;
    assign stat_hits = 16'd0;
`endif
endmodule

// File: tb/tb_sme_host_tx.sv
// Scoreboard bench for sme_host_tx: expected SME characters and results are queued at
// stimulus time and popped as the DUT emits traffic and res_valid strobes.
module tb_sme_host_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0, wr_sel = 1'b0, clr = 1'b0, start = 1'b0, send_str = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic        sme_valid = 1'b0, sme_match = 1'b0;
    logic [4:0]  sme_match_index = 5'd0;
    logic        busy, err, sme_isstring, sme_ispattern, res_valid, res_match, res_timeout;
    logic [7:0]  sme_chardata;
    logic [4:0]  res_index;
    logic [15:0] stat_jobs, stat_hits;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {logic isstr; logic [7:0] ch;} chr_t;
    typedef struct packed {logic m; logic [4:0] idx; logic tmo;} res_t;
    chr_t exp_chr[$];
    res_t exp_res[$];

    sme_host_tx dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .clr(clr), .start(start), .send_str(send_str), .busy(busy), .err(err),
        .sme_chardata(sme_chardata), .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
        .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
        .res_timeout(res_timeout), .stat_jobs(stat_jobs), .stat_hits(stat_hits)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : char_monitor
        chr_t e;
        if (!reset && (sme_isstring || sme_ispattern)) begin
            n_tests++;
            if (exp_chr.size() == 0) begin
                n_fail++;
                $display("FAIL chr_unexpected: got isstr=%0b ispat=%0b char=%h, required no traffic",
                         sme_isstring, sme_ispattern, sme_chardata);
            end else begin
                e = exp_chr.pop_front();
                if ({sme_isstring, sme_ispattern, sme_chardata} !== {e.isstr, ~e.isstr, e.ch}) begin
                    n_fail++;
                    $display("FAIL chr_stream: got isstr=%0b ispat=%0b char=%h, required isstr=%0b ispat=%0b char=%h",
                             sme_isstring, sme_ispattern, sme_chardata, e.isstr, ~e.isstr, e.ch);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic sel, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clear(input logic sel);
        clr = 1'b1; wr_sel = sel;
        tick();
        clr = 1'b0;
    endtask

    task automatic load(input logic sel, input string s);
        clear(sel);
        for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
    endtask

    task automatic expect_chars(input logic isstr, input string s);
        chr_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.isstr = isstr; e.ch = s[i];
            exp_chr.push_back(e);
        end
    endtask

    task automatic go(input logic ss);
        start = 1'b1; send_str = ss;
        tick();
        start = 1'b0; send_str = 1'b0;
    endtask

    // Plays the SME: counts contiguous traffic, then answers on the delay-th WAIT cycle.
    task automatic run_job(input logic do_resp, input logic m, input logic [4:0] idx, input int delay,
                           input int limit, output logic got, output int tlen, output int gaps, output int w);
        logic in_wait = 1'b0;
        got = 1'b0; tlen = 0; gaps = 0; w = 0;
        for (int c = 0; c < limit; c++) begin
            if (res_valid === 1'b1) begin got = 1'b1; break; end
            if (sme_isstring || sme_ispattern) begin
                if (in_wait) gaps++;
                else tlen++;
            end else in_wait = 1'b1;
            sme_valid = 1'b0;
            if (in_wait) begin
                w++;
                if (do_resp && w == delay) begin
                    sme_valid = 1'b1; sme_match = m; sme_match_index = idx;
                end
            end
            tick();
        end
        sme_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({busy, err, sme_isstring, sme_ispattern, sme_chardata, res_valid, res_match, res_index,
             res_timeout, stat_jobs, stat_hits} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b err=%0b isstr=%0b ispat=%0b char=%h rv=%0b rm=%0b ri=%0d rt=%0b jobs=%0d hits=%0d, required all 0",
                     busy, err, sme_isstring, sme_ispattern, sme_chardata, res_valid, res_match,
                     res_index, res_timeout, stat_jobs, stat_hits);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reject();
        load(1'b1, "cd");
        go(1'b0);
        n_tests++;
        if ({err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL reject_no_string: got err=%0b busy=%0b, required err=1 busy=0", err, busy);
        end
        tick();
        n_tests++;
        if ({err, busy} !== 2'b00) begin
            n_fail++; $display("FAIL reject_err_pulse: got err=%0b busy=%0b, required err=0 busy=0", err, busy);
        end
        clear(1'b1);
        load(1'b0, "abcde");
        go(1'b1);
        n_tests++;
        if ({err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL reject_empty_pat: got err=%0b busy=%0b, required err=1 busy=0", err, busy);
        end
        tick();
    endtask

    task automatic test_basic();
        logic got; int tlen, gaps, w; res_t r;
        load(1'b1, "cd");
        expect_chars(1'b1, "abcde");
        expect_chars(1'b0, "cd");
        exp_res.push_back(res_t'({1'b1, 5'd2, 1'b0}));
        go(1'b1);
        n_tests++;
        if ({busy, sme_isstring, sme_chardata} !== {1'b1, 1'b1, 8'h61}) begin
            n_fail++; $display("FAIL basic_first_char: got busy=%0b isstr=%0b char=%h, required 1 1 61",
                               busy, sme_isstring, sme_chardata);
        end
        run_job(1'b1, 1'b1, 5'd2, 3, 100, got, tlen, gaps, w);
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL basic_result: no res_valid within 100 cycles, required one");
        end else begin
            r = exp_res.pop_front();
            if ({res_match, res_index, res_timeout, busy} !== {r, 1'b1}) begin
                n_fail++; $display("FAIL basic_result: got m=%0b idx=%0d tmo=%0b busy=%0b, required m=%0b idx=%0d tmo=%0b busy=1",
                                   res_match, res_index, res_timeout, busy, r.m, r.idx, r.tmo);
            end
        end
        n_tests++;
        if (tlen != 7 || gaps != 0) begin
            n_fail++; $display("FAIL basic_traffic: got %0d chars %0d gaps, required 7 chars 0 gaps", tlen, gaps);
        end
        tick();
        n_tests++;
        if ({busy, res_valid, res_match, res_index} !== {1'b0, 1'b0, 1'b1, 5'd2}) begin
            n_fail++; $display("FAIL basic_hold: got busy=%0b rv=%0b m=%0b idx=%0d, required 0 0 1 2",
                               busy, res_valid, res_match, res_index);
        end
    endtask

    task automatic test_pat_only();
        logic got; int tlen, gaps, w; res_t r;
        load(1'b1, "xy");
        expect_chars(1'b0, "xy");
        exp_res.push_back(res_t'({1'b0, 5'd0, 1'b0}));
        go(1'b0);
        run_job(1'b1, 1'b0, 5'd9, 2, 100, got, tlen, gaps, w);
        n_tests++;
        if (!got) begin
            n_fail++; $display("FAIL patonly_result: no res_valid within 100 cycles, required one");
        end else begin
            r = exp_res.pop_front();
            if ({res_match, res_index, res_timeout} !== r) begin
                n_fail++; $display("FAIL patonly_result: got m=%0b idx=%0d tmo=%0b, required m=%0b idx=%0d tmo=%0b",
                                   res_match, res_index, res_timeout, r.m, r.idx, r.tmo);
            end
        end
        n_tests++;
        if (tlen != 2 || gaps != 0) begin
            n_fail++; $display("FAIL patonly_traffic: got %0d chars %0d gaps, required 2 chars 0 gaps", tlen, gaps);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic got; int tlen, gaps, w, nerr; res_t r; string s32;
        s32 = "";
        clear(1'b0);
        nerr = 0;
        for (int i = 0; i < 32; i++) begin
            wr(1'b0, 8'h40 + 8'(i));
            s32 = {s32, string'(8'h40 + 8'(i))};
            if (err !== 1'b0) nerr++;
        end
        n_tests++;
        if (nerr != 0) begin
            n_fail++; $display("FAIL fill_no_err: got %0d err pulses, required 0", nerr);
        end
        wr(1'b0, 8'hEE);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL overflow_err: got err=%0b, required 1", err);
        end
        for (int j = 0; j < 2; j++) begin
            expect_chars(1'b1, s32);
            expect_chars(1'b0, "xy");
            exp_res.push_back(res_t'({1'b1, 5'd31, 1'b0}));
            go(1'b1);
            if (j == 0) begin
                wr(1'b0, 8'h55);
                n_tests++;
                if (err !== 1'b1) begin
                    n_fail++; $display("FAIL busy_write_err: got err=%0b, required 1", err);
                end
            end
            run_job(1'b1, 1'b1, 5'd31, 1, 200, got, tlen, gaps, w);
            n_tests++;
            if (!got) begin
                n_fail++; $display("FAIL overflow_result: no res_valid within 200 cycles, required one");
            end else begin
                r = exp_res.pop_front();
                if ({res_match, res_index, res_timeout} !== r) begin
                    n_fail++; $display("FAIL overflow_result: got m=%0b idx=%0d tmo=%0b, required m=%0b idx=%0d tmo=%0b",
                                       res_match, res_index, res_timeout, r.m, r.idx, r.tmo);
                end
            end
            if (j == 1) begin
                n_tests++;
                if (tlen != 34 || gaps != 0) begin
                    n_fail++; $display("FAIL str_cnt_32: got %0d chars %0d gaps, required 34 chars 0 gaps", tlen, gaps);
                end
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        logic got; int tlen, gaps, w; res_t r;
        for (int j = 0; j < 2; j++) begin
            expect_chars(1'b0, "xy");
            exp_res.push_back(j == 0 ? res_t'({1'b0, 5'd0, 1'b1}) : res_t'({1'b1, 5'd7, 1'b0}));
            go(1'b0);
            run_job(j == 1, 1'b1, 5'd7, 1024, 1200, got, tlen, gaps, w);
            n_tests++;
            if (!got) begin
                n_fail++; $display("FAIL timeout_result_%0d: no res_valid within 1200 cycles, required one", j);
            end else begin
                r = exp_res.pop_front();
                if ({res_match, res_index, res_timeout} !== r) begin
                    n_fail++; $display("FAIL timeout_result_%0d: got m=%0b idx=%0d tmo=%0b, required m=%0b idx=%0d tmo=%0b",
                                       j, res_match, res_index, res_timeout, r.m, r.idx, r.tmo);
                end
            end
            n_tests++;
            if (w != 1024 || tlen != 2) begin
                n_fail++; $display("FAIL timeout_cycles_%0d: got %0d wait cycles %0d chars, required 1024 and 2", j, w, tlen);
            end
            tick();
        end
    endtask

    task automatic test_reset_midjob();
        int nrv;
        load(1'b0, "abcde");
        expect_chars(1'b1, "abcde");
        expect_chars(1'b0, "xy");
        go(1'b1);
        tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if ({sme_isstring, sme_ispattern, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_abort: got isstr=%0b ispat=%0b busy=%0b, required 0 0 0",
                               sme_isstring, sme_ispattern, busy);
        end
        reset = 1'b0;
        exp_chr.delete();
        nrv = 0;
        repeat (20) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0) nrv++;
        end
        n_tests++;
        if (nrv != 0) begin
            n_fail++; $display("FAIL reset_no_result: got %0d cycles with res_valid/busy, required 0", nrv);
        end
        load(1'b1, "cd");
        go(1'b0);
        n_tests++;
        if ({err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL str_loaded_cleared: got err=%0b busy=%0b, required err=1 busy=0", err, busy);
        end
        tick();
        go(1'b1);
        n_tests++;
        if ({err, busy} !== 2'b10) begin
            n_fail++; $display("FAIL str_cnt_cleared: got err=%0b busy=%0b, required err=1 busy=0", err, busy);
        end
        tick();
    endtask

    task automatic test_stats();
        logic got; int tlen, gaps, w; res_t r;
        load(1'b0, "abcde");
        for (int j = 0; j < 3; j++) begin
            if (j == 0) expect_chars(1'b1, "abcde");
            expect_chars(1'b0, "cd");
            exp_res.push_back(j == 0 ? res_t'({1'b1, 5'd2, 1'b0}) : res_t'({1'b0, 5'd0, 1'b0}));
            go(j == 0);
            run_job(1'b1, j == 0, 5'd2 + 5'(j), 1 + j, 100, got, tlen, gaps, w);
            n_tests++;
            if (!got) begin
                n_fail++; $display("FAIL stats_job_%0d: no res_valid within 100 cycles, required one", j);
            end else begin
                r = exp_res.pop_front();
                if ({res_match, res_index, res_timeout} !== r) begin
                    n_fail++; $display("FAIL stats_job_%0d: got m=%0b idx=%0d tmo=%0b, required m=%0b idx=%0d tmo=%0b",
                                       j, res_match, res_index, res_timeout, r.m, r.idx, r.tmo);
                end
            end
            tick();
        end
        n_tests++;
`ifdef SME_TX_STAT_EN
        if ({stat_jobs, stat_hits} !== {16'd3, 16'd1}) begin
            n_fail++; $display("FAIL stats_counts: got jobs=%0d hits=%0d, required jobs=3 hits=1", stat_jobs, stat_hits);
        end
`else
        if ({stat_jobs, stat_hits} !== 32'd0) begin
            n_fail++; $display("FAIL stats_tied: got jobs=%0d hits=%0d, required 0 0", stat_jobs, stat_hits);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_reject();
        test_basic();
        test_pat_only();
        test_overflow();
        test_timeout();
        test_reset_midjob();
        test_stats();
        n_tests++;
        if (exp_chr.size() != 0 || exp_res.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d chars %0d results left, required 0 0",
                               exp_chr.size(), exp_res.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sme_host_tx.md
Name: sme_host_tx

Overview:
- Initiator side of the string-matching-engine (SME) character-stream protocol. It drives chardata/isstring/ispattern and collects valid/match/match_index.
- A host CPU or bus loads one string and one pattern into internal byte buffers, then issues start. The block serializes the buffers onto the SME interface, waits for the SME verdict, and returns it as a one-cycle result.
- It sits between the system bus and the SME in the accelerator wrapper, replacing the behavioural driver used in simulation.

Parameters:
- STR_MAX, 32, string buffer depth in bytes (1..32; the SME index is 5 bits).
- PAT_MAX, 8, pattern buffer depth in bytes.
- TIMEOUT, 1024, maximum cycles spent in WAIT before the verdict is forced.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write one byte into the buffer selected by wr_sel.
- wr_sel  in  1  0 = string buffer, 1 = pattern buffer.
- wr_data  in  8  byte to append.
- clr  in  1  empty the buffer selected by wr_sel; takes priority over wr_en in the same cycle.
- start  in  1  one-cycle request to launch a job.
- send_str  in  1  sampled with start: 1 = send string then pattern; 0 = send pattern only, reusing the string already held by the SME.
- busy  out  1  high from the cycle after start is accepted until the cycle res_valid is high, inclusive.
- err  out  1  one-cycle pulse when start is rejected or a write is dropped.
- sme_chardata  out  8  character to the SME.
- sme_isstring  out  1  chardata is a string character.
- sme_ispattern  out  1  chardata is a pattern character.
- sme_valid  in  1  SME verdict strobe.
- sme_match  in  1  SME match flag.
- sme_match_index  in  5  SME match position.
- res_valid  out  1  one-cycle result strobe.
- res_match  out  1  captured match flag.
- res_index  out  5  captured index; 0 when res_match = 0.
- res_timeout  out  1  result was forced by TIMEOUT.
- stat_jobs  out  16  completed job count (see Optional Feature).
- stat_hits  out  16  matched job count (see Optional Feature).

Behaviour:
- Reset:
  - All outputs 0.
  - str_cnt, pat_cnt, the read pointer and the timeout counter cleared.
  - The internal str_loaded flag is cleared; the FSM goes to IDLE.
  - A reset mid-job aborts immediately: no res_valid, and isstring/ispattern are 0 on the next cycle.
- Buffer writes:
  - Accepted only in IDLE. A byte appends at index str_cnt or pat_cnt, and that count increments.
  - A write while busy, or into a full buffer, is dropped and pulses err.
  - clr sets the selected count to 0. Buffer contents are not cleared.
- Start checks: start is accepted in IDLE only and ignored while busy. It is rejected with err, staying in IDLE, when any of these holds:
  - pat_cnt = 0;
  - send_str = 1 and str_cnt = 0;
  - send_str = 0 and str_loaded = 0.
- FSM IDLE -> SEND_STR | SEND_PAT -> WAIT -> DONE -> IDLE.
- All SME-side outputs are registered. The first character appears the cycle after start is accepted.
- SEND_STR:
  - Outputs str[0..str_cnt-1] on consecutive cycles with sme_isstring = 1.
  - After the last character it goes straight to SEND_PAT. The next cycle carries pat[0] with sme_isstring = 0 and sme_ispattern = 1, with no gap.
  - Sets str_loaded = 1.
- SEND_PAT:
  - Outputs pat[0..pat_cnt-1] with sme_ispattern = 1.
  - The cycle after the last character, ispattern = 0 and the FSM enters WAIT.
- Idle drive: sme_chardata holds its last value whenever both is* flags are 0.
- WAIT:
  - On sme_valid = 1, captures match and index, then goes to DONE.
  - sme_valid is ignored in every other state.
  - If TIMEOUT cycles elapse without sme_valid, goes to DONE with res_timeout = 1, res_match = 0 and res_index = 0.
- DONE:
  - res_valid = 1 for exactly one cycle; busy drops on the next cycle.
  - res_match, res_index and res_timeout hold until the next res_valid.
- Simultaneous sme_valid and timeout expiry: sme_valid wins and res_timeout = 0.
- Job latency:
  - With send_str = 1: str_cnt + pat_cnt + 1 cycles to WAIT entry, plus the SME response time.
  - With send_str = 0: pat_cnt + 1 cycles.

Optional Feature:
- SME_TX_STAT_EN defined:
  - stat_jobs increments on every res_valid.
  - stat_hits increments on res_valid with res_match = 1.
  - Both wrap at 16'hFFFF -> 0 and are cleared by reset.
- SME_TX_STAT_EN undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Load string "abcde" and pattern "cd", start with send_str = 1 -> isstring high for exactly 5 cycles (a,b,c,d,e), then ispattern high for exactly 2 cycles (c,d) with no gap. Model returns match = 1, index = 2 -> res_valid with res_match = 1, res_index = 2.
- Replace the pattern with "xy", start with send_str = 0 -> no isstring cycles and 2 ispattern cycles. Model returns match = 0 -> res_match = 0, res_index = 0.
- Start with send_str = 0 directly after reset -> err pulse, busy stays 0, no SME traffic. Start with pattern empty -> err pulse.
- Write 33 string bytes (STR_MAX = 32) -> the 33rd is dropped with err, and str_cnt = 32. A write issued while busy -> dropped with err, and the buffer is unchanged.
- Model never asserts valid -> after 1024 WAIT cycles, res_valid with res_timeout = 1, res_match = 0. Valid in the same cycle as expiry -> res_timeout = 0.
- Assert reset mid-SEND_STR -> next cycle isstring = 0 and busy = 0, with no res_valid. A subsequent send_str = 0 start is rejected with err. With SME_TX_STAT_EN, 3 completed jobs with 1 match -> stat_jobs = 3, stat_hits = 1.
